// File: rtl/risc_mem_pkg.sv
// risc_mem_pkg: shared RAM geometry and read-return owner encoding
package risc_mem_pkg;
  localparam int RAM_AW = 16;
  localparam int RAM_DW = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMP} owner_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive denials of the non-preferred port
module arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over increment; hold once the limit is reached
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != CW'(MAX_WAIT)) ? cnt_q + 1'b1 : cnt_q;
    sat   = cnt_q == CW'(MAX_WAIT);
  end
  // counter register
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: request/grant sharing of the single-port RAM between CPU and dump ports
module ram_port_arbiter
  import risc_mem_pkg::*;
#(
  parameter int AW       = RAM_AW,
  parameter int DW       = RAM_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dump_mode,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dmp_req,
  input  logic [AW-1:0] dmp_addr,
  output logic          dmp_gnt,
  output logic          dmp_rvalid,
  output logic [DW-1:0] dmp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [7:0]    conflict_cnt
);
  owner_t        rd_owner_q, rd_owner_d;
  logic [DW-1:0] cpu_hold_q, cpu_hold_d, dmp_hold_q, dmp_hold_d;
  logic [7:0]    conflict_q, conflict_d;
  logic          dump_mode_q, dump_mode_d;
  logic          sat, mode_chg, q_wins, dmp_win, q_req, q_gnt, inc, clr;
  // a mode change voids the stale starve count for this cycle's arbitration
  always_comb begin
    mode_chg    = dump_mode != dump_mode_q;
    q_wins      = sat & ~mode_chg;
    dmp_win     = dmp_req & (~cpu_req | (dump_mode ^ q_wins));
    dmp_gnt     = reset & dmp_win;
    cpu_gnt     = reset & cpu_req & ~dmp_win;
    q_req       = dump_mode ? cpu_req : dmp_req;
    q_gnt       = dump_mode ? cpu_gnt : dmp_gnt;
    inc         = q_req & ~q_gnt;
    clr         = q_gnt | ~q_req | mode_chg;
    ram_we      = cpu_gnt & cpu_we;
    ram_addr    = dmp_gnt ? dmp_addr : cpu_addr;
    ram_din     = cpu_wdata;
    rd_owner_d  = (cpu_gnt && !cpu_we) ? OWN_CPU : dmp_gnt ? OWN_DMP : OWN_NONE;
    cpu_rvalid  = rd_owner_q == OWN_CPU;
    dmp_rvalid  = rd_owner_q == OWN_DMP;
    cpu_rdata   = cpu_rvalid ? ram_dout : cpu_hold_q;
    dmp_rdata   = dmp_rvalid ? ram_dout : dmp_hold_q;
    cpu_hold_d  = cpu_rdata;
    dmp_hold_d  = dmp_rdata;
    conflict_d  = (cpu_req && dmp_req && conflict_q != 8'hFF) ? conflict_q + 8'd1 : conflict_q;
    conflict_cnt = conflict_q;
    dump_mode_d = dump_mode;
  end
  // read-return owner, held read data, conflict counter and mode history
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_owner_q  <= OWN_NONE;
      cpu_hold_q  <= '0;
      dmp_hold_q  <= '0;
      conflict_q  <= '0;
      dump_mode_q <= 1'b0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      cpu_hold_q  <= cpu_hold_d;
      dmp_hold_q  <= dmp_hold_d;
      conflict_q  <= conflict_d;
      dump_mode_q <= dump_mode_d;
    end
  arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (inc),
    .clr  (clr),
    .sat  (sat)
  );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of arbitration, read return and counters
module tb_ram_port_arbiter;
  logic        clk = 1'b0, reset = 1'b0, dump_mode = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dmp_req = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, dmp_addr = '0;
  logic        cpu_gnt, cpu_rvalid, dmp_gnt, dmp_rvalid, ram_we;
  logic [15:0] cpu_rdata, dmp_rdata, ram_addr, ram_din;
  logic [15:0] ram_dout = '0;
  logic [7:0]  conflict_cnt;
  logic [15:0] mem [256] = '{16: 16'hBEEF, default: 16'h0000};
  int n = 0, errs = 0;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset), .dump_mode(dump_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dmp_req(dmp_req), .dmp_addr(dmp_addr), .dmp_gnt(dmp_gnt),
    .dmp_rvalid(dmp_rvalid), .dmp_rdata(dmp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // 256x16 synchronous RAM, read-before-write
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_din;
    ram_dout <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    step();
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_dmp_rvalid", 32'(dmp_rvalid), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_conflict", 32'(conflict_cnt), 0);
    reset = 1'b1;
    step();
    // 1. reset between a read grant and its return
    cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_we = 1'b0;
    #1 chk("t1_gnt_before_rst", 32'(cpu_gnt), 1);
    #1 reset = 1'b0;
    #1 chk("t1_gnt_in_rst", 32'(cpu_gnt), 0);
    chk("t1_ram_we_in_rst", 32'(ram_we), 0);
    cpu_req = 1'b0;
    step();
    chk("t1_no_rvalid", 32'(cpu_rvalid), 0);
    chk("t1_rdata_zero", 32'(cpu_rdata), 0);
    reset = 1'b1;
    step();
    chk("t1_no_rvalid_after", 32'(cpu_rvalid), 0);
    // 2. CPU read of 0x10
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    #1 chk("t2_cpu_gnt", 32'(cpu_gnt), 1);
    chk("t2_dmp_gnt", 32'(dmp_gnt), 0);
    chk("t2_ram_addr", 32'(ram_addr), 32'h10);
    chk("t2_ram_we", 32'(ram_we), 0);
    step();
    cpu_req = 1'b0;
    #1 chk("t2_rvalid", 32'(cpu_rvalid), 1);
    chk("t2_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("t2_dmp_rvalid", 32'(dmp_rvalid), 0);
    step();
    chk("t2_rvalid_drop", 32'(cpu_rvalid), 0);
    chk("t2_rdata_hold", 32'(cpu_rdata), 32'hBEEF);
    // 3. CPU write then dump read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    #1 chk("t3_gnt", 32'(cpu_gnt), 1);
    chk("t3_ram_we", 32'(ram_we), 1);
    chk("t3_ram_din", 32'(ram_din), 32'h1234);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1 chk("t3_no_rvalid", 32'(cpu_rvalid), 0);
    dmp_req = 1'b1; dmp_addr = 16'h0020;
    #1 chk("t3_dmp_gnt", 32'(dmp_gnt), 1);
    chk("t3_dmp_addr", 32'(ram_addr), 32'h20);
    step();
    dmp_req = 1'b0;
    #1 chk("t3_dmp_rvalid", 32'(dmp_rvalid), 1);
    chk("t3_dmp_rdata", 32'(dmp_rdata), 32'h1234);
    chk("t3_cpu_rdata_hold", 32'(cpu_rdata), 32'hBEEF);
    step();
    // 4. contention with CPU preferred: 4 CPU grants then 1 dump grant
    cpu_req = 1'b1; cpu_addr = 16'h0010; dmp_req = 1'b1; dmp_addr = 16'h0020;
    for (int k = 0; k < 10; k++) begin
      #1 chk("t4_cpu_gnt", 32'(cpu_gnt), 32'((k % 5) != 4));
      chk("t4_dmp_gnt", 32'(dmp_gnt), 32'((k % 5) == 4));
      step();
    end
    chk("t4_conflict", 32'(conflict_cnt), 10);
    // 5. mode flip 0->1 with the dump port one cycle from its starvation grant
    for (int k = 0; k < 4; k++) begin
      #1 chk("t5_cpu_pre", 32'(cpu_gnt), 1);
      step();
    end
    dump_mode = 1'b1;
    #1 chk("t5_dmp_same_cycle", 32'(dmp_gnt), 1);
    chk("t5_cpu_denied", 32'(cpu_gnt), 0);
    step();
    for (int k = 0; k < 5; k++) begin
      #1 chk("t5_dmp_gnt", 32'(dmp_gnt), 32'(k < 4));
      chk("t5_cpu_gnt", 32'(cpu_gnt), 32'(k == 4));
      step();
    end
    chk("t5_conflict", 32'(conflict_cnt), 20);
    cpu_req = 1'b0; dmp_req = 1'b0; dump_mode = 1'b0;
    step();
    step();
    // 6. long contention: routing of interleaved reads and conflict saturation
    cpu_req = 1'b1; dmp_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1 chk("t6_cpu_gnt", 32'(cpu_gnt), 32'((k % 5) != 4));
      chk("t6_cpu_rvalid", 32'(cpu_rvalid), 32'(k > 0 && ((k - 1) % 5) != 4));
      chk("t6_dmp_rvalid", 32'(dmp_rvalid), 32'(k > 0 && ((k - 1) % 5) == 4));
      chk("t6_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
      chk("t6_dmp_rdata", 32'(dmp_rdata), 32'h1234);
      step();
    end
    chk("t6_conflict_sat", 32'(conflict_cnt), 32'hFF);
    cpu_req = 1'b0; dmp_req = 1'b0;
    step();
    step();
    chk("t6_conflict_hold", 32'(conflict_cnt), 32'hFF);
    chk("t6_idle_no_gnt", 32'({cpu_gnt, dmp_gnt}), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
